maxpool_stream: RTL and testbench

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of the convolution data path and consumes one conv/ReLU result per valid cycle. It produces the subsampled feature map in raster order. Feature maps arrive channel after channel, and the block reports channel and frame completion to the layer controller.

---
 rtl/maxpool_stream.sv | 119 +++++++++++
 tb/tb_maxpool_stream.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// Streaming 2x2 / stride-2 max-pool stage. One pixel per valid cycle in raster,
// channel-major order; one pooled pixel out per completed window, no backpressure.
module maxpool_stream #(
  parameter int DATA_WIDTH    = 32,
  parameter int ARITH_TYPE    = 1,
  parameter int IFM_SIZE      = 28,
  parameter int IFM_DEPTH     = 6,
  parameter int IFM_SIZE_NEXT = IFM_SIZE / 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  data_in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  channel_done,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int COL_W = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
  localparam int CH_W  = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
  localparam int LB_W  = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IFM_SIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(IFM_DEPTH - 1);

  logic [COL_W-1:0]      col;
  logic [COL_W-1:0]      row;
  logic [CH_W-1:0]       ch;
  logic [DATA_WIDTH-1:0] h;
  logic [DATA_WIDTH-1:0] lb [IFM_SIZE_NEXT];
  logic [LB_W-1:0]       lb_idx;
  logic [DATA_WIDTH-1:0] m;
  logic [DATA_WIDTH-1:0] pooled;
  logic                  col_last;
  logic                  row_last;
  logic                  ch_last;

  // Returns a unless b is strictly greater, so ties keep the earlier operand.
  // Float mode compares sign-magnitude; +0 and -0 compare equal.
  function automatic logic [DATA_WIDTH-1:0] max_sel(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic b_wins;
    if (ARITH_TYPE == 0)
      b_wins = $signed(b) > $signed(a);
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      b_wins = a[DATA_WIDTH-1] && ((a[DATA_WIDTH-2:0] != '0) || (b[DATA_WIDTH-2:0] != '0));
    else if (!a[DATA_WIDTH-1])
      b_wins = b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0];
    else
      b_wins = b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0];
    return b_wins ? b : a;
  endfunction

  assign col_last = (col == COL_LAST);
  assign row_last = (row == COL_LAST);
  assign ch_last  = (ch == CH_LAST);
  assign lb_idx   = LB_W'(col >> 1);
  assign m        = max_sel(h, data_in);
  assign pooled   = max_sel(lb[lb_idx], m);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col            <= '0;
      row            <= '0;
      ch             <= '0;
      h              <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      channel_done   <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
    end else if (clear) begin
      col            <= '0;
      row            <= '0;
      ch             <= '0;
      h              <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      channel_done   <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      channel_done   <= 1'b0;
      frame_done     <= 1'b0;
      if (data_in_valid) begin
        busy <= !(col_last && row_last && ch_last);
        if (!col[0]) begin
          h <= data_in;
        end else if (row[0]) begin
          data_out       <= pooled;
          data_out_valid <= 1'b1;
          channel_done   <= col_last && row_last;
          frame_done     <= col_last && row_last && ch_last;
        end
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row <= '0;
            ch  <= ch_last ? '0 : ch + CH_W'(1);
          end else begin
            row <= row + COL_W'(1);
          end
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Line buffer holds the top-row pair maxima; contents are irrelevant after reset.
  always_ff @(posedge clk) begin
    if (data_in_valid && !clear && col[0] && !row[0])
      lb[lb_idx] <= m;
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: four instances covering fixed/float compare,
// multi-channel gapped input, abort recovery and the full 28x28x6 geometry.
module tb_maxpool_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  vld;
  logic [3:0]  clr;
  logic [31:0] din  [4];
  logic [31:0] dout [4];
  logic [3:0]  dv, cd, fd, bsy;

  always #5 clk = ~clk;

  maxpool_stream #(.DATA_WIDTH(32), .ARITH_TYPE(0), .IFM_SIZE(4), .IFM_DEPTH(1)) u_fix (
    .clk(clk), .reset(reset), .clear(clr[0]), .data_in_valid(vld[0]), .data_in(din[0]),
    .data_out_valid(dv[0]), .data_out(dout[0]), .channel_done(cd[0]), .frame_done(fd[0]),
    .busy(bsy[0]));
  maxpool_stream #(.DATA_WIDTH(32), .ARITH_TYPE(1), .IFM_SIZE(4), .IFM_DEPTH(1)) u_flt (
    .clk(clk), .reset(reset), .clear(clr[1]), .data_in_valid(vld[1]), .data_in(din[1]),
    .data_out_valid(dv[1]), .data_out(dout[1]), .channel_done(cd[1]), .frame_done(fd[1]),
    .busy(bsy[1]));
  maxpool_stream #(.DATA_WIDTH(32), .ARITH_TYPE(0), .IFM_SIZE(4), .IFM_DEPTH(2)) u_gap (
    .clk(clk), .reset(reset), .clear(clr[2]), .data_in_valid(vld[2]), .data_in(din[2]),
    .data_out_valid(dv[2]), .data_out(dout[2]), .channel_done(cd[2]), .frame_done(fd[2]),
    .busy(bsy[2]));
  maxpool_stream #(.DATA_WIDTH(32), .ARITH_TYPE(1), .IFM_SIZE(28), .IFM_DEPTH(6)) u_lenet (
    .clk(clk), .reset(reset), .clear(clr[3]), .data_in_valid(vld[3]), .data_in(din[3]),
    .data_out_valid(dv[3]), .data_out(dout[3]), .channel_done(cd[3]), .frame_done(fd[3]),
    .busy(bsy[3]));

  int          n_chk = 0;
  int          n_fail = 0;
  int          mcol [4];
  int          mrow [4];
  int          mch  [4];
  logic [31:0] img  [4][28][28];
  bit          exp_due [4];
  bit          exp_cd  [4];
  bit          exp_fd  [4];
  bit          mbusy   [4];
  bit          chk_now [4];
  logic [31:0] exp_val [4];
  int          n_out [4];
  int          n_cd  [4];
  int          n_fd  [4];
  logic [31:0] olog  [4][64];

  int sv [16] = '{-3, -8, 5, 9, -1, -2, 7, -20, 0, -5, -100, -50, -7, -1, -60, -200};
  logic [31:0] fv [16] = '{
    32'hBF800000, 32'h3F000000, 32'h80000000, 32'h00000000,
    32'h80000000, 32'hC0000000, 32'hC0800000, 32'hC0A00000,
    32'h3F800000, 32'h40000000, 32'hC0400000, 32'h00000000,
    32'h40400000, 32'hBF000000, 32'h80000000, 32'hC0800000};

  function automatic int sz(input int k);
    return (k == 3) ? 28 : 4;
  endfunction

  function automatic int dep(input int k);
    return (k == 3) ? 6 : ((k == 2) ? 2 : 1);
  endfunction

  function automatic bit is_flt(input int k);
    return (k == 1) || (k == 3);
  endfunction

  // Float values mapped onto a signed ordering key; both zeros map to 0.
  function automatic logic signed [32:0] fkey(input logic [31:0] a);
    logic signed [32:0] mag;
    mag = $signed({2'b00, a[30:0]});
    return a[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b, input bit f);
    if (f) return (fkey(b) > fkey(a)) ? b : a;
    return ($signed(b) > $signed(a)) ? b : a;
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [31:0] r;
    r = $urandom;
    if (r[3:0] == 4'd0) return {r[31], 31'd0};
    return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
  endfunction

  task automatic check_eq(input string tag, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", tag, k, act, exp);
    end
  endtask

  task automatic model_clear(input int k);
    mcol[k] = 0; mrow[k] = 0; mch[k] = 0;
    exp_due[k] = 0; chk_now[k] = 0; mbusy[k] = 0;
  endtask

  task automatic model_accept(input int k, input logic [31:0] x);
    int r, c, s;
    bit f;
    r = mrow[k]; c = mcol[k]; s = sz(k); f = is_flt(k);
    img[k][r][c] = x;
    chk_now[k] = 1;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      exp_val[k] = fmax(fmax(img[k][r-1][c-1], img[k][r-1][c], f),
                        fmax(img[k][r][c-1], x, f), f);
      exp_due[k] = 1;
      exp_cd[k]  = (r == s - 1) && (c == s - 1);
      exp_fd[k]  = exp_cd[k] && (mch[k] == dep(k) - 1);
    end
    mbusy[k] = !((r == s - 1) && (c == s - 1) && (mch[k] == dep(k) - 1));
    if (c == s - 1) begin
      mcol[k] = 0;
      if (r == s - 1) begin
        mrow[k] = 0;
        mch[k]  = (mch[k] == dep(k) - 1) ? 0 : mch[k] + 1;
      end else begin
        mrow[k] = r + 1;
      end
    end else begin
      mcol[k] = c + 1;
    end
  endtask

  // Advance one clock and compare every instance against the model.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (exp_due[k] || dv[k]) check_eq("valid", k, 32'(dv[k]), 32'(exp_due[k]));
      if (exp_due[k]) begin
        check_eq("data", k, dout[k], exp_val[k]);
        check_eq("channel_done", k, 32'(cd[k]), 32'(exp_cd[k]));
        check_eq("frame_done", k, 32'(fd[k]), 32'(exp_fd[k]));
      end
      if (chk_now[k]) check_eq("busy", k, 32'(bsy[k]), 32'(mbusy[k]));
      if (dv[k]) begin
        if (n_out[k] < 64) olog[k][n_out[k]] = dout[k];
        n_out[k]++;
      end
      if (cd[k]) n_cd[k]++;
      if (fd[k]) n_fd[k]++;
      exp_due[k] = 0;
      chk_now[k] = 0;
    end
  endtask

  task automatic cycle(input int k, input bit v, input logic [31:0] x, input bit c);
    vld[k] = v; din[k] = x; clr[k] = c;
    if (c) model_clear(k);
    else if (v) model_accept(k, x);
    step();
    vld[k] = 1'b0; clr[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [31:0] x);
    cycle(k, 1'b1, x, 1'b0);
  endtask

  task automatic ramp(input int k);
    for (int i = 0; i < 16; i++) send(k, 32'(i));
    step();
  endtask

  task automatic expect_log(input string tag, input int k, input int base,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    check_eq({tag, "_count"}, k, 32'(n_out[k] - base), 32'd4);
    check_eq({tag, "_out0"}, k, olog[k][base], e0);
    check_eq({tag, "_out1"}, k, olog[k][base+1], e1);
    check_eq({tag, "_out2"}, k, olog[k][base+2], e2);
    check_eq({tag, "_out3"}, k, olog[k][base+3], e3);
  endtask

  initial begin
    int base, cd0, fd0, sent;
    bit v;
    reset = 1'b0; vld = '0; clr = '0;
    for (int k = 0; k < 4; k++) begin
      din[k] = '0; n_out[k] = 0; n_cd[k] = 0; n_fd[k] = 0;
      model_clear(k);
    end
    repeat (3) step();
    for (int k = 0; k < 4; k++) begin
      check_eq("rst_valid", k, 32'(dv[k]), 32'd0);
      check_eq("rst_data", k, dout[k], 32'd0);
      check_eq("rst_chan", k, 32'(cd[k]), 32'd0);
      check_eq("rst_frame", k, 32'(fd[k]), 32'd0);
      check_eq("rst_busy", k, 32'(bsy[k]), 32'd0);
    end
    reset = 1'b1;
    step();

    // Fixed-point ramp
    base = n_out[0]; cd0 = n_cd[0]; fd0 = n_fd[0];
    ramp(0);
    expect_log("ramp", 0, base, 32'd5, 32'd7, 32'd13, 32'd15);
    check_eq("ramp_chan_pulses", 0, 32'(n_cd[0] - cd0), 32'd1);
    check_eq("ramp_frame_pulses", 0, 32'(n_fd[0] - fd0), 32'd1);
    check_eq("ramp_busy_end", 0, 32'(bsy[0]), 32'd0);

    // Signed windows
    base = n_out[0];
    for (int i = 0; i < 16; i++) send(0, 32'(sv[i]));
    step();
    expect_log("signed", 0, base, 32'hFFFFFFFF, 32'd9, 32'd0, 32'hFFFFFFCE);

    // Float sign-magnitude windows, including +/-0 ties
    base = n_out[1];
    for (int i = 0; i < 16; i++) send(1, fv[i]);
    step();
    expect_log("float", 1, base, 32'h3F000000, 32'h80000000, 32'h40400000, 32'h00000000);

    // Gapped, two channels
    base = n_out[2]; cd0 = n_cd[2]; fd0 = n_fd[2]; sent = 0;
    while (sent < 32) begin
      v = 1'($urandom_range(0, 1));
      cycle(2, v, $urandom, 1'b0);
      if (v) sent++;
    end
    repeat (2) step();
    check_eq("gap_outputs", 2, 32'(n_out[2] - base), 32'd8);
    check_eq("gap_chan_pulses", 2, 32'(n_cd[2] - cd0), 32'd2);
    check_eq("gap_frame_pulses", 2, 32'(n_fd[2] - fd0), 32'd1);
    check_eq("gap_busy_end", 2, 32'(bsy[2]), 32'd0);

    // Abort with async reset mid-channel
    for (int i = 0; i < 9; i++) send(0, 32'(100 + i));
    check_eq("abort_busy_before", 0, 32'(bsy[0]), 32'd1);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) model_clear(k);
    repeat (2) step();
    check_eq("abort_rst_valid", 0, 32'(dv[0]), 32'd0);
    check_eq("abort_rst_data", 0, dout[0], 32'd0);
    check_eq("abort_rst_busy", 0, 32'(bsy[0]), 32'd0);
    reset = 1'b1;
    step();
    base = n_out[0];
    ramp(0);
    expect_log("after_reset", 0, base, 32'd5, 32'd7, 32'd13, 32'd15);

    // Abort with clear; the pixel presented alongside clear must be dropped
    for (int i = 0; i < 9; i++) send(0, 32'(200 + i));
    cycle(0, 1'b1, 32'd999, 1'b1);
    check_eq("clear_busy", 0, 32'(bsy[0]), 32'd0);
    check_eq("clear_data", 0, dout[0], 32'd0);
    base = n_out[0];
    ramp(0);
    expect_log("after_clear", 0, base, 32'd5, 32'd7, 32'd13, 32'd15);

    // Full LeNet geometry, two frames back to back
    base = n_out[3]; cd0 = n_cd[3]; fd0 = n_fd[3];
    for (int i = 0; i < 2 * 28 * 28 * 6; i++) send(3, rnd_f());
    repeat (3) step();
    check_eq("lenet_outputs", 3, 32'(n_out[3] - base), 32'd2352);
    check_eq("lenet_chan_pulses", 3, 32'(n_cd[3] - cd0), 32'd12);
    check_eq("lenet_frame_pulses", 3, 32'(n_fd[3] - fd0), 32'd2);
    check_eq("lenet_busy_end", 3, 32'(bsy[3]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
